// File: rtl/rgb_pkg.sv
// Shared colour types and the per-channel step function used by the fader;
// the LED driver reuses rgb_t.
package rgb_pkg;

  localparam int NUM_CH = 3;

  typedef logic [7:0] chan_t;

  typedef struct packed {
    chan_t r;
    chan_t g;
    chan_t b;
  } rgb_t;

  // Distance is taken 9 bits wide so cur +/- step can never wrap past tgt.
  function automatic chan_t step_chan(chan_t cur, chan_t tgt, chan_t step);
    logic [8:0] diff;
    if (cur < tgt) diff = {1'b0, tgt} - {1'b0, cur};
    else           diff = {1'b0, cur} - {1'b0, tgt};
    if (diff <= {1'b0, step}) return tgt;
    else if (cur < tgt)       return cur + step;
    else                      return cur - step;
  endfunction

endpackage

// File: rtl/rgb_step_channel.sv
// One colour channel: next value after a fade step and whether that value
// lands on the target.
module rgb_step_channel
  import rgb_pkg::*;
(
  input  chan_t cur,
  input  chan_t tgt,
  input  chan_t step,
  output chan_t nxt,
  output logic  at_tgt
);

  assign nxt    = step_chan(cur, tgt, step);
  assign at_tgt = (nxt == tgt);

endmodule

// File: rtl/rgb_fader.sv
// Colour command sequencer: accepts a target colour and walks rgb toward it
// in fixed per-channel steps at STEP_HZ, pulsing done on arrival.
module rgb_fader
  import rgb_pkg::*;
#(
  parameter int          CLK_HZ      = 27_000_000,
  parameter int          STEP_HZ     = 1000,
  parameter logic [23:0] DEFAULT_RGB = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_rgb,
  input  logic [7:0]  cmd_step,
  input  logic        cmd_blink,
  output logic [23:0] rgb,
  output logic        blink_en,
  output logic        busy,
  output logic        done
);

  localparam int STEP_DIV = CLK_HZ / STEP_HZ;
  localparam int PW       = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

  typedef enum logic {IDLE, FADE} state_t;

  state_t                       state;
  rgb_t                         rgb_q, tgt_q;
  chan_t                        step_q;
  logic [PW-1:0]                pre;
  logic                         blink_q, done_q;

  logic [NUM_CH-1:0][7:0]       cur_v, tgt_v, nxt_v;
  logic [NUM_CH-1:0]            at_v;
  rgb_t                         nxt_rgb;

  assign cur_v   = rgb_q;
  assign tgt_v   = tgt_q;
  assign nxt_rgb = nxt_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rgb_step_channel u_ch (
      .cur    (cur_v[i]),
      .tgt    (tgt_v[i]),
      .step   (step_q),
      .nxt    (nxt_v[i]),
      .at_tgt (at_v[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rgb_q   <= DEFAULT_RGB;
      tgt_q   <= '0;
      step_q  <= '0;
      pre     <= '0;
      blink_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            tgt_q   <= cmd_rgb;
            step_q  <= cmd_step;
            blink_q <= cmd_blink;
            pre     <= '0;
            // Zero step or no distance: jump and finish on the accept edge.
            if (cmd_step == 8'd0 || cmd_rgb == rgb_q) begin
              rgb_q  <= cmd_rgb;
              done_q <= 1'b1;
            end else begin
              state <= FADE;
            end
          end
        end
        FADE: begin
          if (pre == PW'(STEP_DIV - 1)) begin
            pre   <= '0;
            rgb_q <= nxt_rgb;
            if (&at_v) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end else begin
            pre <= pre + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == FADE);
  assign rgb       = rgb_q;
  assign blink_en  = blink_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rgb_fader.sv
// Directed bench for rgb_fader at STEP_DIV=4: table of chained commands plus
// hand sequences for reset, backpressure and reset mid-fade.
module tb_rgb_fader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [23:0] cmd_rgb = '0;
  logic [7:0]  cmd_step = '0;
  logic        cmd_blink = 1'b0;
  logic [23:0] rgb;
  logic        blink_en, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  rgb_fader #(.CLK_HZ(8), .STEP_HZ(2), .DEFAULT_RGB(24'h000000)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rgb   (cmd_rgb),
    .cmd_step  (cmd_step),
    .cmd_blink (cmd_blink),
    .rgb       (rgb),
    .blink_en  (blink_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] rgb;
    logic [7:0]  step;
    logic        blink;
    int          ticks;
    logic [23:0] first;
    logic [23:0] fin;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [23:0] c, input logic [7:0] s, input logic b);
    cmd_rgb   = c;
    cmd_step  = s;
    cmd_blink = b;
    cmd_valid = 1'b1;
    edge1();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [23:0] prev;
    int cyc;

    vecs[0] = '{24'hFF0000, 8'h00, 1'b1, 0,  24'hFF0000, 24'hFF0000};
    vecs[1] = '{24'h000000, 8'h40, 1'b0, 4,  24'hBF0000, 24'h000000};
    vecs[2] = '{24'h0A0000, 8'h04, 1'b1, 3,  24'h040000, 24'h0A0000};
    vecs[3] = '{24'hFFA050, 8'h00, 1'b0, 0,  24'hFFA050, 24'hFFA050};
    vecs[4] = '{24'h00A0FF, 8'h80, 1'b1, 2,  24'h7FA0D0, 24'h00A0FF};
    vecs[5] = '{24'h00A0FF, 8'h05, 1'b0, 0,  24'h00A0FF, 24'h00A0FF};
    vecs[6] = '{24'h102030, 8'h08, 1'b1, 26, 24'h0898F7, 24'h102030};
    vecs[7] = '{24'h01FF02, 8'hFF, 1'b0, 1,  24'h01FF02, 24'h01FF02};
    vecs[8] = '{24'hFF00FF, 8'hFE, 1'b1, 2,  24'hFF01FF, 24'hFF00FF};

    // Reset state held across edges
    repeat (2) edge1();
    chk("rst_rgb",   32'(rgb), 32'h0);
    chk("rst_blink", 32'(blink_en), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h1);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    rst = 1'b0;
    edge1();

    prev = 24'h000000;
    for (int v = 0; v < 9; v++) begin
      chk($sformatf("v%0d_ready_pre", v), 32'(cmd_ready), 32'h1);
      accept(vecs[v].rgb, vecs[v].step, vecs[v].blink);
      chk($sformatf("v%0d_blink", v), 32'(blink_en), 32'(vecs[v].blink));
      chk($sformatf("v%0d_done_acc", v), 32'(done), 32'(vecs[v].ticks == 0));
      chk($sformatf("v%0d_busy_acc", v), 32'(busy), 32'(vecs[v].ticks != 0));
      if (vecs[v].ticks == 0) begin
        chk($sformatf("v%0d_rgb_jump", v), 32'(rgb), 32'(vecs[v].fin));
      end else begin
        chk($sformatf("v%0d_rgb_acc", v), 32'(rgb), 32'(prev));
        cyc = 0;
        while (!done && cyc < 200) begin
          edge1();
          cyc++;
          if (cyc == 3) chk($sformatf("v%0d_rgb_hold", v), 32'(rgb), 32'(prev));
          if (cyc == 4) chk($sformatf("v%0d_rgb_first", v), 32'(rgb), 32'(vecs[v].first));
        end
        chk($sformatf("v%0d_cycles", v), 32'(cyc), 32'(vecs[v].ticks * 4));
        chk($sformatf("v%0d_rgb_fin", v), 32'(rgb), 32'(vecs[v].fin));
        chk($sformatf("v%0d_ready_done", v), 32'(cmd_ready), 32'h1);
      end
      edge1();
      chk($sformatf("v%0d_done_low", v), 32'(done), 32'h0);
      chk($sformatf("v%0d_rgb_stable", v), 32'(rgb), 32'(vecs[v].fin));
      prev = vecs[v].fin;
    end

    // Backpressure: command held during a fade, taken on the edge after done
    accept(24'h000000, 8'h00, 1'b0);
    edge1();
    accept(24'h080000, 8'h04, 1'b1);
    cmd_rgb   = 24'h123456;
    cmd_step  = 8'h00;
    cmd_blink = 1'b0;
    cmd_valid = 1'b1;
    cyc = 0;
    while (!done && cyc < 50) begin
      edge1();
      cyc++;
      if (cyc == 6) chk("bp_ready_fade", 32'(cmd_ready), 32'h0);
    end
    chk("bp_cycles", 32'(cyc), 32'd8);
    chk("bp_rgb_done", 32'(rgb), 32'h080000);
    chk("bp_blink_kept", 32'(blink_en), 32'h1);
    edge1();
    cmd_valid = 1'b0;
    chk("bp_rgb_taken", 32'(rgb), 32'h123456);
    chk("bp_done_taken", 32'(done), 32'h1);
    chk("bp_blink_taken", 32'(blink_en), 32'h0);
    edge1();

    // Reset asserted between edges at N+6 of a fade-up
    accept(24'h000000, 8'h00, 1'b1);
    edge1();
    accept(24'h0A0000, 8'h04, 1'b1);
    repeat (6) edge1();
    chk("mr_rgb_pre", 32'(rgb), 32'h040000);
    chk("mr_busy_pre", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_async_rgb",   32'(rgb), 32'h0);
    chk("mr_async_busy",  32'(busy), 32'h0);
    chk("mr_async_ready", 32'(cmd_ready), 32'h1);
    chk("mr_async_blink", 32'(blink_en), 32'h0);
    edge1();
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      edge1();
      if (done || rgb != 24'h0) cyc++;
    end
    chk("mr_no_done", 32'(cyc), 32'h0);
    accept(24'h112233, 8'h00, 1'b0);
    chk("mr_new_rgb",  32'(rgb), 32'h112233);
    chk("mr_new_done", 32'(done), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_fader.md
# rgb_fader

Colour sequencing stage upstream of the RGB LED PWM driver. Accepts colour commands over a valid/ready handshake and walks the 24-bit `rgb` output from its current value toward the commanded target in fixed-size per-channel steps at a programmable step rate. Drives the driver's `rgb` and `blink_en` inputs directly, producing smooth fades instead of hard colour jumps.

## Interface
- `CLK_HZ`, 27_000_000: clock frequency in Hz.
- `STEP_HZ`, 1000: fade step rate in Hz; `STEP_DIV = CLK_HZ / STEP_HZ` must be ≥ 2.
- `DEFAULT_RGB`, 24'h000000: `rgb` value at reset.
- `clk`  in  1  system clock (27 MHz).
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command (high only in IDLE).
- `cmd_rgb`  in  24  target colour {R[23:16], G[15:8], B[7:0]}.
- `cmd_step`  in  8  per-channel step size; 0 = immediate jump.
- `cmd_blink`  in  1  blink enable to forward.
- `rgb`  out  24  current colour, registered.
- `blink_en`  out  1  registered blink enable.
- `busy`  out  1  fade in progress (= state FADE).
- `done`  out  1  one-cycle pulse when `rgb` reaches target.

## Operation
- Reset values: `rgb`=DEFAULT_RGB, `blink_en`=0, `done`=0, state IDLE (`cmd_ready`=1, `busy`=0), prescaler=0, target/step registers=0.
- Accept occurs on a rising edge with `cmd_valid && cmd_ready`. On accept: latch `cmd_rgb`→target, `cmd_step`→step; `blink_en`←`cmd_blink`; prescaler←0.
- IDLE, on accept:
  - `cmd_step`==0 or `cmd_rgb`==`rgb`: `rgb`←`cmd_rgb`, `done`←1 on the same edge; remain IDLE.
  - otherwise → FADE.
- FADE: prescaler counts 0..STEP_DIV-1 and wraps. On the edge where prescaler==STEP_DIV-1 (a tick), for each channel independently: if |cur−tgt| ≤ step then cur←tgt; else cur←cur+step (cur<tgt) or cur−step (cur>tgt). Compute the difference 9 bits wide; no channel may ever overshoot or wrap.
- On the tick where all three channels equal target after update: `done`←1, state→IDLE on that same edge.
- `cmd_valid` in FADE is ignored (`cmd_ready`=0); no abort/queueing.
- `cmd_ready`=(state==IDLE), `busy`=(state==FADE), both decoded combinationally from the state register.
- `done` is high for exactly one cycle and otherwise 0.
- `rst` mid-fade: all registers return to their reset values immediately, fade discarded.

## Timing
- Accept at edge N. Jump case: `rgb`/`done` update at edge N; `done` low again after edge N+1.
- Fade case: k-th step applied at edge N+k·STEP_DIV; fade of S ticks completes at edge N+S·STEP_DIV with `done`; `cmd_ready` high in the cycle that follows.
- S = max over channels of ceil(|tgt−cur|/step).
- `blink_en` changes at accept edge N, independent of fade progress.
- Back-to-back: a new command can be accepted on the edge after the `done` edge.

## Structure
- Shared package `rgb_pkg`: `rgb_t` (24-bit packed struct r/g/b), `chan_t` (8-bit), function `step_chan(cur, tgt, step)` returning the next channel value; the LED driver reuses `rgb_t`.
- State enum (IDLE, FADE) local to the module.
- One natural sub-module: `rgb_step_channel` (per-channel step and at-target flag), instantiated three times.

## Test plan
Bench params: CLK_HZ=8, STEP_HZ=2 (STEP_DIV=4).
- Reset: hold `rst`=1 → `rgb`=000000, `blink_en`=0, `cmd_ready`=1, `busy`=0, `done`=0; assert `rst` asynchronously between edges → outputs change without a clock edge.
- Jump: cmd FF0000, step 0, blink 1 at edge N → `rgb`=FF0000 and `done`=1 at N, `blink_en`=1, `cmd_ready` stays 1.
- Fade up: from 000000, cmd 0A0000 step 4 → R=04 at N+4, 08 at N+8, 0A at N+12 with `done`; `busy`=1 from N to N+12.
- Mixed direction: from FFA050, cmd 00A0FF step 80 → N+4: 7FA0D0; N+8: 00A0FF with `done`; G constant throughout.
- Backpressure: hold `cmd_valid` with cmd 123456 during a fade → ignored until IDLE, accepted on the first edge after the `done` edge.
- Reset mid-fade: assert `rst` at N+6 of the fade-up case → `rgb`=000000, IDLE, no `done`; a new command is accepted normally after release.
